adc_seq_ctrl: RTL

Conversion sequencer for the dual-slope analog front-end. It owns the afe_sel, afe_reset, ref_sign, range_sel and mode_sel controls that go to the analog top. It runs reset → auto-zero → fixed-time integrate → reference deintegrate, and returns a signed magnitude count. It sits inside the digital top, between the host/measurement request logic and the analog control/status bus.

---
 rtl/adc_seq_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - dual-slope conversion sequencer for the analog front-end
//
// Sequences one conversion: wait for reference, integrator discharge,
// auto-zero, fixed-time integrate, reference deintegrate. Returns the
// deintegrate count with polarity and overrange flags.
//
// Optional build macro: ADC_AUTORANGE_EN (range stepped internally after
// each conversion instead of taken from range_cfg_i).
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-low reset
//   start_i, abort_i     conversion request / abort
//   mode_i, range_cfg_i  measurement mode and manual range, latched at accept
//   comp_i, sat_hi_i, sat_lo_i, ref_ok_i   asynchronous analog status
//   afe_sel_o            one-hot phase select [0]=AZ [1]=VIN [2]=+VREF [3]=-VREF
//   afe_reset_o          integrator discharge
//   ref_sign_o           0:+VREF 1:-VREF
//   range_sel_o, mode_sel_o  range and mode to the AFE
//   busy_o, done_o       conversion in progress / one-cycle result strobe
//   result_o, neg_o, ovr_o   deintegrate count, polarity, overrange

module adc_seq_ctrl #(
   parameter int CNT_W       = 16,
   parameter int RST_CYCLES  = 8,
   parameter int AZ_CYCLES   = 256,
   parameter int INT_CYCLES  = 1000,
   parameter int DEINT_MAX   = 2047,
   parameter int DOWN_THRESH = 90
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [2:0]       mode_i,
   input  logic [4:0]       range_cfg_i,
   input  logic             comp_i,
   input  logic             sat_hi_i,
   input  logic             sat_lo_i,
   input  logic             ref_ok_i,
   output logic [3:0]       afe_sel_o,
   output logic             afe_reset_o,
   output logic             ref_sign_o,
   output logic [4:0]       range_sel_o,
   output logic [2:0]       mode_sel_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] result_o,
   output logic             neg_o,
   output logic             ovr_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_REF_WAIT, S_RST, S_AZ, S_INT, S_DEINT, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] AZ_LAST   = CNT_W'(AZ_CYCLES - 1);
   localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEINT_TOP = CNT_W'(DEINT_MAX);

   localparam logic [3:0] SEL_AZ  = 4'b0001;
   localparam logic [3:0] SEL_VIN = 4'b0010;
   localparam logic [3:0] SEL_PV  = 4'b0100;
   localparam logic [3:0] SEL_NV  = 4'b1000;

   // Two-flop synchronizers; bit [1] is the synced value
   logic [1:0] comp_ff, sat_hi_ff, sat_lo_ff, ref_ok_ff;
   logic       comp_s, sat_s, ref_ok_s;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         comp_ff   <= 2'b00;
         sat_hi_ff <= 2'b00;
         sat_lo_ff <= 2'b00;
         ref_ok_ff <= 2'b00;
      end else begin
         comp_ff   <= {comp_ff[0],   comp_i};
         sat_hi_ff <= {sat_hi_ff[0], sat_hi_i};
         sat_lo_ff <= {sat_lo_ff[0], sat_lo_i};
         ref_ok_ff <= {ref_ok_ff[0], ref_ok_i};
      end
   end

   assign comp_s   = comp_ff[1];
   assign sat_s    = sat_hi_ff[1] | sat_lo_ff[1];
   assign ref_ok_s = ref_ok_ff[1];

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pol;   // comparator level at end of integrate

`ifdef ADC_AUTORANGE_EN
   localparam logic [CNT_W-1:0] DOWN_TH = CNT_W'(DOWN_THRESH);
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         cnt         <= '0;
         pol         <= 1'b0;
         afe_sel_o   <= 4'b0000;
         afe_reset_o <= 1'b0;
         ref_sign_o  <= 1'b0;
         range_sel_o <= 5'd0;
         mode_sel_o  <= 3'd0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         result_o    <= '0;
         neg_o       <= 1'b0;
         ovr_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (abort_i && state != S_IDLE && state != S_DONE) begin
            // Abort: park the AFE with a single discharge cycle, keep results
            state       <= S_IDLE;
            cnt         <= '0;
            afe_sel_o   <= 4'b0000;
            afe_reset_o <= 1'b1;
            busy_o      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  afe_reset_o <= 1'b0;
                  if (start_i && !abort_i) begin
                     mode_sel_o <= mode_i;
`ifndef ADC_AUTORANGE_EN
                     range_sel_o <= range_cfg_i;
`endif
                     busy_o <= 1'b1;
                     state  <= S_REF_WAIT;
                  end
               end
               S_REF_WAIT: begin
                  if (ref_ok_s) begin
                     afe_reset_o <= 1'b1;
                     cnt         <= '0;
                     state       <= S_RST;
                  end
               end
               S_RST: begin
                  if (cnt == RST_LAST) begin
                     afe_reset_o <= 1'b0;
                     afe_sel_o   <= SEL_AZ;
                     cnt         <= '0;
                     state       <= S_AZ;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_AZ: begin
                  if (cnt == AZ_LAST) begin
                     afe_sel_o <= SEL_VIN;
                     cnt       <= '0;
                     state     <= S_INT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_INT: begin
                  if (sat_s) begin
                     afe_sel_o <= 4'b0000;
                     result_o  <= DEINT_TOP;
                     ovr_o     <= 1'b1;
                     neg_o     <= ~comp_s;
                     done_o    <= 1'b1;
                     state     <= S_DONE;
                  end else if (cnt == INT_LAST) begin
                     // Deintegrate against the opposite reference
                     pol        <= comp_s;
                     ref_sign_o <= comp_s;
                     afe_sel_o  <= comp_s ? SEL_NV : SEL_PV;
                     cnt        <= '0;
                     state      <= S_DEINT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DEINT: begin
                  if (sat_s) begin
                     result_o <= DEINT_TOP;
                     ovr_o    <= 1'b1;
                  end else if (comp_s != pol) begin
                     result_o <= cnt;
                     ovr_o    <= 1'b0;
                  end else if (cnt == DEINT_TOP) begin
                     result_o <= DEINT_TOP;
                     ovr_o    <= 1'b1;
                  end
                  if (sat_s || comp_s != pol || cnt == DEINT_TOP) begin
                     afe_sel_o <= 4'b0000;
                     neg_o     <= ~pol;
                     done_o    <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DONE: begin
`ifdef ADC_AUTORANGE_EN
                  // Step range for the next conversion from this result
                  if (ovr_o) begin
                     if (range_sel_o != 5'd31) range_sel_o <= range_sel_o + 5'd1;
                  end else if (result_o < DOWN_TH && range_sel_o != 5'd0) begin
                     range_sel_o <= range_sel_o - 5'd1;
                  end
`endif
                  afe_sel_o <= 4'b0000;
                  busy_o    <= 1'b0;
                  cnt       <= '0;
                  state     <= S_IDLE;
               end
               default: begin
                  afe_sel_o   <= 4'b0000;
                  afe_reset_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
